bullet_engine: RTL and testbench
================================

Name: bullet_engine

Overview:
Per-tank bullet generator: the producing end of the bullet-collision interface.
- Accepts a fire request from the tank controller, launches one bullet from the tank edge in the tank's facing direction, and moves it once per frame.
- Drives the per-pixel bullet flag consumed by the collision block.
- Reacts to that block's bullet-explode flag, or to the screen border, by running a timed explosion.
- Instantiated once per player and per enemy.

Parameters:
H_RES, 640, horizontal screen size in pixels
V_RES, 480, vertical screen size in pixels
COORD_W, 10, coordinate width
TANK_SIZE, 16, tank square edge in pixels
BULLET_SIZE, 4, bullet square edge in pixels
SPEED, 4, pixels moved per frame_tick_i
EXPLODE_FRAMES, 8, explosion duration in frames

Ports:
clk_i  in  1  system clock
reset_i  in  1  reset; asynchronous, active-high
frame_tick_i  in  1  one-cycle pulse once per frame
fire_i  in  1  fire request (level or pulse)
enable_i  in  1  tank alive; fire is accepted only when 1
tank_x_i  in  COORD_W  tank top-left x
tank_y_i  in  COORD_W  tank top-left y
tank_dir_i  in  2  direction: 0 up, 1 right, 2 down, 3 left
pixel_x_i  in  COORD_W  current scan pixel x
pixel_y_i  in  COORD_W  current scan pixel y
explose_i  in  1  bullet-explode flag from collision block
fire_ack_o  out  1  one-cycle pulse when a bullet is launched
bullet_pixel_o  out  1  scan pixel inside flying bullet
explode_pixel_o  out  1  scan pixel inside explosion box
busy_o  out  1  state is not IDLE
bullet_x_o  out  COORD_W  bullet top-left x
bullet_y_o  out  COORD_W  bullet top-left y

Behaviour:
Reset (asynchronous, immediate):
- State IDLE; bx, by, direction register and frame counter all 0.
- All outputs 0.
- Applies equally mid-flight and mid-explosion.

State machine: IDLE, FLY, EXPLODE.

IDLE:
- If fire_i && enable_i: latch tank_dir_i into the direction register, pulse fire_ack_o for exactly one cycle, and load the launch position.
- Launch position (O = (TANK_SIZE-BULLET_SIZE)/2):
  - up: (tx+O, ty-BULLET_SIZE)
  - right: (tx+TANK_SIZE, ty+O)
  - down: (tx+O, ty+TANK_SIZE)
  - left: (tx-BULLET_SIZE, ty+O)
- Off-screen launch check, evaluated at COORD_W+1 bits:
  - up: ty<BULLET_SIZE
  - left: tx<BULLET_SIZE
  - right: tx+TANK_SIZE+BULLET_SIZE>H_RES
  - down: ty+TANK_SIZE+BULLET_SIZE>V_RES
- Off-screen launch: the underflowing coordinate is clamped to 0 (up/left only); still ack, then go EXPLODE. Otherwise go FLY.

FLY:
- Priority 1: explose_i=1 on any cycle → EXPLODE next cycle; position frozen. This holds even when frame_tick_i is high in the same cycle.
- Priority 2, on frame_tick_i only, border check:
  - up: by<SPEED
  - left: bx<SPEED
  - down: by+BULLET_SIZE+SPEED>V_RES
  - right: bx+BULLET_SIZE+SPEED>H_RES
- Border hit → EXPLODE without moving. Otherwise move by SPEED along the latched direction.
- enable_i going low does not stop a bullet already in flight.
- fire_i is ignored and fire_ack_o stays 0.

EXPLODE:
- Counter clears on entry.
- Each frame_tick_i increments the counter; the tick that finds counter==EXPLODE_FRAMES-1 returns the state to IDLE.
- fire_i is ignored.

Pixel outputs (combinational from registered bx/by and the pixel inputs; zero latency relative to pixel_x_i/pixel_y_i):
- bullet_pixel_o = FLY && bx<=px<bx+BULLET_SIZE && by<=py<by+BULLET_SIZE.
- explode_pixel_o = EXPLODE && bx-BULLET_SIZE<=px<bx+2*BULLET_SIZE, with the same condition in y.
- Comparisons are done signed at COORD_W+2 bits, so the box never wraps at the screen edge.

Other outputs:
- busy_o = state!=IDLE.
- bullet_x_o/bullet_y_o are the registered bx/by.

Throughput: at most one bullet in flight. A new fire is accepted on the first IDLE cycle after EXPLODE ends.

Test Plan:
- Tank (100,200), dir up, fire_i 1 cycle → fire_ack_o single pulse, bullet at (106,196); after 3 frame ticks by=184; bullet_pixel_o=1 only for px 106..109, py 184..187.
- FLY at (106,184); explose_i and frame_tick_i in the same cycle → position stays (106,184), EXPLODE; explode_pixel_o covers px/py 102..113 and 180..191; after 8 ticks busy_o=0 and the next fire is accepted.
- Dir left, bx=6 → tick gives bx=2; next tick (2<4) → EXPLODE with bx=2, no underflow or wrap.
- Fire during FLY and during EXPLODE, and fire with enable_i=0 in IDLE → no ack, state and position unchanged; enable_i dropped mid-FLY → bullet keeps moving.
- Tank at y=2, dir up → ack, by=0, direct entry to EXPLODE; explode_pixel_o never asserts for negative rows; tank at x=620 dir right → ack then EXPLODE.
- reset_i asserted mid-FLY between clock edges → all outputs 0 immediately; after release, fire works normally.

Source files
------------

// File: rtl/bullet_engine.sv
// bullet_engine: per-tank bullet generator feeding the collision block.
// Launches one bullet from the tank edge on an accepted fire request. Moves it
// SPEED pixels per frame tick and runs a timed explosion when the collision
// block flags a hit or the bullet reaches the screen border.
//
// Ports:
//   clk_i, reset_i              clock, asynchronous active-high reset
//   frame_tick_i                one-cycle pulse per frame
//   fire_i, enable_i            fire request; accepted only while the tank is alive
//   tank_x_i/_y_i, tank_dir_i   tank top-left and facing (0 up,1 right,2 down,3 left)
//   pixel_x_i/_y_i              current scan pixel
//   explose_i                   bullet-explode flag from the collision block
//   fire_ack_o                  one-cycle pulse, coincident with the loaded launch position
//   bullet_pixel_o              scan pixel lies inside the flying bullet
//   explode_pixel_o             scan pixel lies inside the explosion box
//   busy_o                      engine not idle
//   bullet_x_o/_y_o             bullet top-left
module bullet_engine #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int COORD_W        = 10,
  parameter int TANK_SIZE      = 16,
  parameter int BULLET_SIZE    = 4,
  parameter int SPEED          = 4,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               frame_tick_i,
  input  logic               fire_i,
  input  logic               enable_i,
  input  logic [COORD_W-1:0] tank_x_i,
  input  logic [COORD_W-1:0] tank_y_i,
  input  logic [1:0]         tank_dir_i,
  input  logic [COORD_W-1:0] pixel_x_i,
  input  logic [COORD_W-1:0] pixel_y_i,
  input  logic               explose_i,
  output logic               fire_ack_o,
  output logic               bullet_pixel_o,
  output logic               explode_pixel_o,
  output logic               busy_o,
  output logic [COORD_W-1:0] bullet_x_o,
  output logic [COORD_W-1:0] bullet_y_o
);

  localparam int EW    = COORD_W + 1;
  localparam int SW    = COORD_W + 2;
  localparam int CNT_W = $clog2(EXPLODE_FRAMES + 1);

  localparam logic [COORD_W-1:0] OFS_C = COORD_W'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [COORD_W-1:0] TS_C  = COORD_W'(TANK_SIZE);
  localparam logic [COORD_W-1:0] BS_C  = COORD_W'(BULLET_SIZE);
  localparam logic [COORD_W-1:0] SP_C  = COORD_W'(SPEED);
  localparam logic [EW-1:0]      TS_E  = EW'(TANK_SIZE);
  localparam logic [EW-1:0]      BS_E  = EW'(BULLET_SIZE);
  localparam logic [EW-1:0]      SP_E  = EW'(SPEED);
  localparam logic [EW-1:0]      HR_E  = EW'(H_RES);
  localparam logic [EW-1:0]      VR_E  = EW'(V_RES);
  localparam logic signed [SW-1:0] BS_S  = SW'(BULLET_SIZE);
  localparam logic signed [SW-1:0] BS2_S = SW'(2 * BULLET_SIZE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(EXPLODE_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_EXPLODE} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic [1:0]         dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               off_scr, hit;

  // Zero-extended copies so edge checks cannot overflow.
  logic [EW-1:0] tx_e, ty_e, bx_e, by_e;
  assign tx_e = {1'b0, tank_x_i};
  assign ty_e = {1'b0, tank_y_i};
  assign bx_e = {1'b0, bx_q};
  assign by_e = {1'b0, by_q};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      dir_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    off_scr = 1'b0;
    hit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fire_i && enable_i) begin
          dir_d = tank_dir_i;
          ack_d = 1'b1;
          cnt_d = '0;
          case (tank_dir_i)
            2'd0: begin
              off_scr = ty_e < BS_E;
              bx_d    = tank_x_i + OFS_C;
              by_d    = off_scr ? '0 : tank_y_i - BS_C;
            end
            2'd1: begin
              off_scr = (tx_e + TS_E + BS_E) > HR_E;
              bx_d    = tank_x_i + TS_C;
              by_d    = tank_y_i + OFS_C;
            end
            2'd2: begin
              off_scr = (ty_e + TS_E + BS_E) > VR_E;
              bx_d    = tank_x_i + OFS_C;
              by_d    = tank_y_i + TS_C;
            end
            default: begin
              off_scr = tx_e < BS_E;
              bx_d    = off_scr ? '0 : tank_x_i - BS_C;
              by_d    = tank_y_i + OFS_C;
            end
          endcase
          state_d = off_scr ? S_EXPLODE : S_FLY;
        end
      end
      S_FLY: begin
        // A collision flag wins over a same-cycle frame tick: position stays put.
        if (explose_i) begin
          state_d = S_EXPLODE;
          cnt_d   = '0;
        end else if (frame_tick_i) begin
          case (dir_q)
            2'd0:    hit = by_e < SP_E;
            2'd1:    hit = (bx_e + BS_E + SP_E) > HR_E;
            2'd2:    hit = (by_e + BS_E + SP_E) > VR_E;
            default: hit = bx_e < SP_E;
          endcase
          if (hit) begin
            state_d = S_EXPLODE;
            cnt_d   = '0;
          end else begin
            case (dir_q)
              2'd0:    by_d = by_q - SP_C;
              2'd1:    bx_d = bx_q + SP_C;
              2'd2:    by_d = by_q + SP_C;
              default: bx_d = bx_q - SP_C;
            endcase
          end
        end
      end
      S_EXPLODE: begin
        if (frame_tick_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Signed compare at COORD_W+2 bits so the explosion box can extend past
  // the top/left edge without wrapping around to the far side.
  logic signed [SW-1:0] px_s, py_s, bx_s, by_s;
  assign px_s = signed'({2'b00, pixel_x_i});
  assign py_s = signed'({2'b00, pixel_y_i});
  assign bx_s = signed'({2'b00, bx_q});
  assign by_s = signed'({2'b00, by_q});

  logic in_bul_x, in_bul_y, in_exp_x, in_exp_y;
  assign in_bul_x = (px_s >= bx_s) && (px_s < bx_s + BS_S);
  assign in_bul_y = (py_s >= by_s) && (py_s < by_s + BS_S);
  assign in_exp_x = (px_s >= bx_s - BS_S) && (px_s < bx_s + BS2_S);
  assign in_exp_y = (py_s >= by_s - BS_S) && (py_s < by_s + BS2_S);

  assign bullet_pixel_o  = (state_q == S_FLY) && in_bul_x && in_bul_y;
  assign explode_pixel_o = (state_q == S_EXPLODE) && in_exp_x && in_exp_y;
  assign busy_o          = (state_q != S_IDLE);
  assign fire_ack_o      = ack_q;
  assign bullet_x_o      = bx_q;
  assign bullet_y_o      = by_q;

endmodule

// File: tb/tb_bullet_engine.sv
module tb_bullet_engine;
  localparam int HR = 640, VR = 480, TS = 16, BS = 4, SP = 4, EF = 8, OFS = 6;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       frame_tick_i = 1'b0, fire_i = 1'b0, enable_i = 1'b1, explose_i = 1'b0;
  logic [9:0] tank_x_i = '0, tank_y_i = '0, pixel_x_i = '0, pixel_y_i = '0;
  logic [1:0] tank_dir_i = '0;
  logic       fire_ack_o, bullet_pixel_o, explode_pixel_o, busy_o;
  logic [9:0] bullet_x_o, bullet_y_o;

  bullet_engine dut (
    .clk_i(clk_i), .reset_i(reset_i), .frame_tick_i(frame_tick_i),
    .fire_i(fire_i), .enable_i(enable_i), .tank_x_i(tank_x_i), .tank_y_i(tank_y_i),
    .tank_dir_i(tank_dir_i), .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i),
    .explose_i(explose_i), .fire_ack_o(fire_ack_o), .bullet_pixel_o(bullet_pixel_o),
    .explode_pixel_o(explode_pixel_o), .busy_o(busy_o),
    .bullet_x_o(bullet_x_o), .bullet_y_o(bullet_y_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_miss = 0;

  // Reference model: 0 idle, 1 flying, 2 exploding; plain integer coordinates.
  int m_st = 0, m_bx = 0, m_by = 0, m_dir = 0, m_cnt = 0, m_ack = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_bullet_pix(int px, int py);
    return m_st == 1 && px >= m_bx && px < m_bx + BS && py >= m_by && py < m_by + BS;
  endfunction

  function automatic bit m_explode_pix(int px, int py);
    return m_st == 2 && px >= m_bx - BS && px < m_bx + 2 * BS &&
           py >= m_by - BS && py < m_by + 2 * BS;
  endfunction

  // Next model state from the inputs present before the clock edge.
  function automatic void model_step();
    int tx, ty;
    bit off, hit;
    tx = int'(tank_x_i);
    ty = int'(tank_y_i);
    m_ack = 0;
    case (m_st)
      0: if (fire_i && enable_i) begin
        m_ack = 1;
        m_dir = int'(tank_dir_i);
        m_cnt = 0;
        case (m_dir)
          0: begin off = ty < BS; m_bx = tx + OFS; m_by = off ? 0 : ty - BS; end
          1: begin off = tx + TS + BS > HR; m_bx = tx + TS; m_by = ty + OFS; end
          2: begin off = ty + TS + BS > VR; m_bx = tx + OFS; m_by = ty + TS; end
          default: begin off = tx < BS; m_bx = off ? 0 : tx - BS; m_by = ty + OFS; end
        endcase
        m_st = off ? 2 : 1;
      end
      1: if (explose_i) begin
        m_st = 2; m_cnt = 0;
      end else if (frame_tick_i) begin
        case (m_dir)
          0: hit = m_by < SP;
          1: hit = m_bx + BS + SP > HR;
          2: hit = m_by + BS + SP > VR;
          default: hit = m_bx < SP;
        endcase
        if (hit) begin
          m_st = 2; m_cnt = 0;
        end else begin
          case (m_dir)
            0: m_by -= SP;
            1: m_bx += SP;
            2: m_by += SP;
            default: m_bx -= SP;
          endcase
        end
      end
      default: if (frame_tick_i) begin
        if (m_cnt == EF - 1) m_st = 0;
        else m_cnt++;
      end
    endcase
  endfunction

  task automatic cmp_all(input string tag);
    chk({tag, ".ack"}, fire_ack_o, m_ack);
    chk({tag, ".busy"}, busy_o, m_st != 0);
    chk({tag, ".bx"}, bullet_x_o, m_bx);
    chk({tag, ".by"}, bullet_y_o, m_by);
    chk({tag, ".bpix"}, bullet_pixel_o, m_bullet_pix(int'(pixel_x_i), int'(pixel_y_i)));
    chk({tag, ".epix"}, explode_pixel_o, m_explode_pix(int'(pixel_x_i), int'(pixel_y_i)));
  endtask

  task automatic cycle(input string tag = "cyc");
    model_step();
    @(posedge clk_i);
    #1;
    cmp_all(tag);
  endtask

  task automatic tick(input string tag = "tick");
    frame_tick_i = 1'b1;
    cycle(tag);
    frame_tick_i = 1'b0;
  endtask

  task automatic fire_once(input int tx, input int ty, input int dir, input string tag);
    tank_x_i = 10'(tx); tank_y_i = 10'(ty); tank_dir_i = 2'(dir);
    fire_i = 1'b1;
    cycle(tag);
    fire_i = 1'b0;
  endtask

  // Combinational pixel probe; control inputs are quiet while it runs.
  task automatic pix(input int px, input int py, input string tag);
    pixel_x_i = 10'(px);
    pixel_y_i = 10'(py);
    #1;
    chk({tag, ".bpix"}, bullet_pixel_o, m_bullet_pix(px, py));
    chk({tag, ".epix"}, explode_pixel_o, m_explode_pix(px, py));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #3;
    reset_i = 1'b1;
    #1;
    chk("rst.ack", fire_ack_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.bx", bullet_x_o, 0);
    chk("rst.by", bullet_y_o, 0);
    chk("rst.bpix", bullet_pixel_o, 0);
    chk("rst.epix", explode_pixel_o, 0);
    m_st = 0; m_bx = 0; m_by = 0; m_dir = 0; m_cnt = 0; m_ack = 0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  typedef struct {
    int tx, ty, dir;
    int ebx, eby;
    bit eexp;
  } launch_t;
  launch_t tbl[12];

  initial begin
    tbl[0]  = '{100, 200, 0, 106, 196, 0};
    tbl[1]  = '{100, 200, 1, 116, 206, 0};
    tbl[2]  = '{100, 200, 2, 106, 216, 0};
    tbl[3]  = '{100, 200, 3,  96, 206, 0};
    tbl[4]  = '{100,   2, 0, 106,   0, 1};
    tbl[5]  = '{100,   4, 0, 106,   0, 0};
    tbl[6]  = '{  3, 100, 3,   0, 106, 1};
    tbl[7]  = '{  4, 100, 3,   0, 106, 0};
    tbl[8]  = '{620, 100, 1, 636, 106, 0};
    tbl[9]  = '{621, 100, 1, 637, 106, 1};
    tbl[10] = '{100, 460, 2, 106, 476, 0};
    tbl[11] = '{100, 461, 2, 106, 477, 1};

    reset_i = 1'b1;
    #12;
    reset_i = 1'b0;
    do_reset();

    // Launch table: position, ack and resulting state for each direction/edge.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      pixel_x_i = 10'(tbl[i].ebx);
      pixel_y_i = 10'(tbl[i].eby);
      fire_once(tbl[i].tx, tbl[i].ty, tbl[i].dir, "launch");
      chk("tbl.ack", fire_ack_o, 1);
      chk("tbl.bx", bullet_x_o, tbl[i].ebx);
      chk("tbl.by", bullet_y_o, tbl[i].eby);
      chk("tbl.bpix", bullet_pixel_o, !tbl[i].eexp);
      chk("tbl.epix", explode_pixel_o, tbl[i].eexp);
    end

    // Right-edge launch that fits: first tick hits the border.
    do_reset();
    fire_once(620, 100, 1, "r620");
    tick("r620.t");
    chk("r620.busy", busy_o, 1);
    chk("r620.bx", bullet_x_o, 636);
    pix(640 - 10, 110, "r620.box");

    // Up-fire flight, pixel sweep, explode on same cycle as a tick.
    do_reset();
    fire_once(100, 200, 0, "up");
    chk("up.ack", fire_ack_o, 1);
    cycle("up.ack0");
    chk("up.ackpulse", fire_ack_o, 0);
    for (int k = 0; k < 3; k++) begin tick("up.t"); cycle("up.idle"); end
    chk("up.by184", bullet_y_o, 184);
    for (int px = 103; px <= 112; px++) pix(px, 185, "up.scanx");
    for (int py = 181; py <= 190; py++) pix(107, py, "up.scany");
    fire_i = 1'b1;
    cycle("up.fireInFly");
    fire_i = 1'b0;
    chk("fly.noack", fire_ack_o, 0);
    explose_i = 1'b1;
    frame_tick_i = 1'b1;
    cycle("up.expl");
    explose_i = 1'b0;
    frame_tick_i = 1'b0;
    chk("expl.bx", bullet_x_o, 106);
    chk("expl.by", bullet_y_o, 184);
    for (int px = 100; px <= 115; px++) pix(px, 185, "ex.scanx");
    for (int py = 178; py <= 193; py++) pix(107, py, "ex.scany");
    pix(102, 180, "ex.cornerIn");
    pix(113, 191, "ex.cornerIn2");
    pix(114, 191, "ex.cornerOut");
    fire_i = 1'b1;
    cycle("ex.fire");
    fire_i = 1'b0;
    chk("ex.noack", fire_ack_o, 0);
    for (int k = 0; k < EF; k++) begin
      chk("ex.busy", busy_o, 1);
      tick("ex.t");
    end
    chk("ex.done", busy_o, 0);
    fire_once(100, 200, 0, "refire");
    chk("refire.ack", fire_ack_o, 1);

    // Left flight toward x=0: 6 -> 2 -> border explosion at 2.
    do_reset();
    fire_once(10, 50, 3, "left");
    chk("left.bx6", bullet_x_o, 6);
    tick("left.t1");
    chk("left.bx2", bullet_x_o, 2);
    tick("left.t2");
    chk("left.expl", busy_o, 1);
    chk("left.bxfrozen", bullet_x_o, 2);
    for (int px = 0; px <= 11; px++) pix(px, 58, "left.scan");
    pix(1023, 58, "left.nowrap");

    // Off-screen up launch: explosion rows above 0 must not wrap.
    do_reset();
    fire_once(100, 2, 0, "top");
    for (int py = 0; py <= 9; py++) pix(106, py, "top.scan");
    for (int py = 1019; py <= 1023; py++) pix(106, py, "top.nowrap");

    // Fire with enable low, then enable dropped mid-flight.
    do_reset();
    enable_i = 1'b0;
    fire_once(100, 200, 1, "dis");
    chk("dis.noack", fire_ack_o, 0);
    chk("dis.idle", busy_o, 0);
    enable_i = 1'b1;
    fire_once(100, 200, 1, "en");
    enable_i = 1'b0;
    tick("en.t");
    chk("en.moved", bullet_x_o, 120);
    enable_i = 1'b1;

    // Asynchronous reset mid-flight, then normal fire.
    pixel_x_i = 10'(m_bx);
    pixel_y_i = 10'(m_by);
    #1;
    chk("midfly.bpix", bullet_pixel_o, 1);
    do_reset();
    fire_once(200, 100, 2, "postrst");
    chk("postrst.ack", fire_ack_o, 1);
    chk("postrst.by", bullet_y_o, 116);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      fire_i       = ($urandom_range(0, 7) == 0);
      enable_i     = ($urandom_range(0, 9) != 0);
      frame_tick_i = ($urandom_range(0, 2) == 0);
      explose_i    = ($urandom_range(0, 30) == 0);
      tank_x_i     = 10'($urandom_range(0, HR - 1));
      tank_y_i     = 10'($urandom_range(0, VR - 1));
      tank_dir_i   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        pixel_x_i = 10'((m_bx + $urandom_range(0, 15) - 6) & 1023);
        pixel_y_i = 10'((m_by + $urandom_range(0, 15) - 6) & 1023);
      end else begin
        pixel_x_i = 10'($urandom_range(0, 1023));
        pixel_y_i = 10'($urandom_range(0, 1023));
      end
      cycle("rnd");
    end
    fire_i = 1'b0; frame_tick_i = 1'b0; explose_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
